// File: rtl/stream_split_pkg.sv
// Shared definitions for the stream channel splitter.
// Contents:
//   MaxCh          - largest supported channel count
//   MaxCntW        - widest supported drop counter
//   cnt_sat_t      - container type for the drop counter saturation value
//   ch_offset()    - bit offset of a channel's slice in a flattened data bus
//   cnt_sat_value()- all-ones saturation value for a counter of given width
package stream_split_pkg;

  localparam int unsigned MaxCh   = 16;
  localparam int unsigned MaxCntW = 32;

  typedef logic [MaxCntW-1:0] cnt_sat_t;

  function automatic int unsigned ch_offset(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

  function automatic cnt_sat_t cnt_sat_value(input int unsigned width);
    cnt_sat_t v;
    v = '0;
    for (int unsigned i = 0; i < MaxCntW; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/split_slot.sv
// One-entry register slice for a single splitter output channel.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   load_i     - capture data_i this cycle (caller guarantees the slot is free)
//   data_i     - word to capture
//   ready_i    - downstream consumer ready
//   valid_o    - slot holds a word
//   data_o     - held word; stable while valid_o && !ready_i
module split_slot
  import stream_split_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      // A load may coincide with a drain; the new word simply replaces the old.
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_channel_splitter.sv
// 1-to-NUM_CH valid/ready stream demultiplexer with broadcast and drop counting.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   in_valid/in_ready - input handshake; in_ready never depends on in_valid
//   in_data           - input word
//   in_sel            - target channel (ignored when in_bcast)
//   in_bcast          - send to every enabled channel at once
//   ch_enable         - per-channel enable mask
//   out_valid/ready   - per-channel output handshake
//   out_data          - channel k at [k*DATA_W +: DATA_W]
//   drop_count        - saturating count of words with an empty target set
//   clr_drop          - synchronous clear of drop_count, wins over an increment
module stream_channel_splitter
  import stream_split_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  // Derived; leave at default.
  parameter int unsigned SEL_W  = $clog2(NUM_CH),
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_count,
  input  logic                     clr_drop
);

  localparam cnt_sat_t         CntSat = cnt_sat_value(CNT_W);
  localparam logic [CNT_W-1:0] CntMax = CntSat[CNT_W-1:0];

  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] load;
  logic              accept;
  logic              drop;
  logic [CNT_W-1:0]  drop_count_d, drop_count_q;

  // An out-of-range in_sel matches no channel, so its target set is empty.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  assign target    = in_bcast ? ch_enable : (sel_hit & ch_enable);
  assign slot_free = ~out_valid | out_ready;

  // Every targeted slot must be free so a broadcast is never split across cycles.
  assign in_ready = &(slot_free | ~target);
  assign accept   = in_valid && in_ready;
  assign load     = target & {NUM_CH{accept}};
  assign drop     = accept && (target == '0);

  always_comb begin
    drop_count_d = drop_count_q;
    if (clr_drop) begin
      drop_count_d = '0;
    end else if (drop && (drop_count_q != CntMax)) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    split_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[ch_offset(k, DATA_W) +: DATA_W])
    );
  end

endmodule
